// File: rtl/fixed_point_formatter_if.sv
// Handshake bundle for the fixed-point formatter.
// The operand side is valid/ready in; the character stream is valid/ready out.
interface fixed_point_formatter_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  result_integer;
  logic [22:0] result_decimal;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  // Producer of operands and consumer of characters.
  modport master (
    output in_valid, result_integer, result_decimal, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  // The formatter itself.
  modport slave (
    input  in_valid, result_integer, result_decimal, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/fixed_point_formatter.sv
// Fixed-point to ASCII decimal formatter.
// Captures a signed 8.23 value, converts the integer magnitude to BCD with a
// double-dabble pass, then streams sign, integer digits, '.', and truncated
// fraction digits through a registered valid/ready output.
module fixed_point_formatter #(
  parameter int FRAC_DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fixed_point_formatter_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, CONV, SIGN, INT, POINT, FRAC} state_e;

  localparam logic [2:0] FD_LAST = (FRAC_DIGITS == 0) ? 3'd0 : 3'(FRAC_DIGITS - 1);

  state_e      state_q, state_d;
  logic        neg_q, neg_d;
  logic        nz_q, nz_d;
  logic [22:0] frac_q, frac_d;
  logic [19:0] dd_q, dd_d;      // {hundreds, tens, ones, binary}
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;    // integer digit being emitted (2 = hundreds)
  logic [2:0]  fcnt_q, fcnt_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;

  logic        in_ready;
  logic [30:0] v;
  logic [31:0] m;
  logic [1:0]  int_start;
  logic [26:0] p;
  logic        have;
  logic        last;
  logic        emit_int;
  logic [1:0]  k;
  logic [3:0]  dig;
  logic [7:0]  ch;
  state_e      nxt;
  logic [1:0]  idx_nxt;
  logic [2:0]  fcnt_nxt;
  logic [22:0] frac_nxt;

  // One double-dabble step: add 3 to any BCD digit >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] x);
    logic [19:0] t;
    t = x;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  // Magnitude is 32 bits wide so -128.0 negates without overflow.
  always_comb begin
    v = {bus.result_integer, bus.result_decimal};
    m = v[30] ? (~{v[30], v} + 32'd1) : {v[30], v};
  end

  assign in_ready      = (state_q == IDLE) && !out_valid_q;
  assign bus.in_ready  = in_ready;
  assign bus.busy      = !in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  // Leading-zero suppression: first integer digit to print.
  always_comb begin
    if (dd_q[19:16] != 4'd0)      int_start = 2'd2;
    else if (dd_q[15:12] != 4'd0) int_start = 2'd1;
    else                          int_start = 2'd0;
  end

  // Next-state, character selection and output register load.
  always_comb begin
    state_d     = state_q;
    neg_d       = neg_q;
    nz_d        = nz_q;
    frac_d      = frac_q;
    dd_d        = dd_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    fcnt_d      = fcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    have        = 1'b0;
    last        = 1'b0;
    emit_int    = 1'b0;
    k           = idx_q;
    dig         = 4'd0;
    ch          = 8'h00;
    nxt         = state_q;
    idx_nxt     = idx_q;
    fcnt_nxt    = fcnt_q;
    frac_nxt    = frac_q;
    p           = {4'd0, frac_q} * 27'd10;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          state_d = CONV;
          neg_d   = v[30];
          nz_d    = |m;
          dd_d    = {12'd0, m[30:23]};
          frac_d  = m[22:0];
          cnt_d   = 3'd0;
        end
      end
      CONV: begin
        dd_d  = dd_step(dd_q);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = SIGN;
      end
      SIGN: begin
        have = 1'b1;
        if (neg_q && nz_q) begin
          ch      = 8'h2D;
          nxt     = INT;
          idx_nxt = int_start;
        end else begin
          // No sign: the first integer digit goes out in this same slot.
          emit_int = 1'b1;
          k        = int_start;
        end
      end
      INT: begin
        have     = 1'b1;
        emit_int = 1'b1;
        k        = idx_q;
      end
      POINT: begin
        have     = 1'b1;
        ch       = 8'h2E;
        nxt      = FRAC;
        fcnt_nxt = 3'd0;
      end
      FRAC: begin
        have     = 1'b1;
        ch       = 8'h30 + {4'd0, p[26:23]};
        frac_nxt = p[22:0];
        fcnt_nxt = fcnt_q + 3'd1;
        if (fcnt_q == FD_LAST) begin
          last = 1'b1;
          nxt  = IDLE;
        end else begin
          nxt  = FRAC;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit_int) begin
      case (k)
        2'd2:    dig = dd_q[19:16];
        2'd1:    dig = dd_q[15:12];
        default: dig = dd_q[11:8];
      endcase
      ch = 8'h30 + {4'd0, dig};
      if (k != 2'd0) begin
        nxt     = INT;
        idx_nxt = k - 2'd1;
      end else if (FRAC_DIGITS == 0) begin
        nxt  = IDLE;
        last = 1'b1;
      end else begin
        nxt  = POINT;
      end
    end

    // Load the next character whenever the output slot is empty or draining.
    if (have && (!out_valid_q || bus.out_ready)) begin
      out_valid_d = 1'b1;
      out_data_d  = ch;
      out_last_d  = last;
      state_d     = nxt;
      idx_d       = idx_nxt;
      fcnt_d      = fcnt_nxt;
      frac_d      = frac_nxt;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      neg_q       <= 1'b0;
      nz_q        <= 1'b0;
      frac_q      <= '0;
      dd_q        <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      fcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      neg_q       <= neg_d;
      nz_q        <= nz_d;
      frac_q      <= frac_d;
      dd_q        <= dd_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      fcnt_q      <= fcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_fixed_point_formatter.sv
// Directed bench for fixed_point_formatter: a 4-fraction-digit instance and a
// 0-fraction-digit instance share clock and reset.
module tb_fixed_point_formatter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  fixed_point_formatter_if b0 ();
  fixed_point_formatter_if b1 ();

  fixed_point_formatter #(.FRAC_DIGITS(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  fixed_point_formatter #(.FRAC_DIGITS(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ov(input bit sel);
    return sel ? b1.out_valid : b0.out_valid;
  endfunction

  // Offer one operand; bounded wait for in_ready. Returns #1 after the accept edge.
  task automatic send(input bit sel, input logic [7:0] i, input logic [22:0] d);
    int w = 0;
    @(negedge clk);
    while (!(sel ? b1.in_ready : b0.in_ready) && w < 100) begin
      @(negedge clk); w++;
    end
    chk("send_ready_timeout", 32'(w < 100), 32'd1);
    if (sel) begin b1.result_integer = i; b1.result_decimal = d; b1.in_valid = 1'b1; end
    else     begin b0.result_integer = i; b0.result_decimal = d; b0.in_valid = 1'b1; end
    @(posedge clk); #1;
    b0.in_valid = 1'b0; b1.in_valid = 1'b0;
  endtask

  // Consume one string, checking characters, out_last placement and stall stability.
  task automatic collect(input bit sel, input string exp, input bit toggle, input string tag);
    int n = 0, bad = 0, cyc = 0;
    bit done = 0, lastbad = 0, unstable = 0, stalled = 0, rdy = 0;
    logic [7:0] hold = 8'h00, od;
    logic ov, ol;
    while (!done && cyc < 300) begin
      @(negedge clk); cyc++;
      ov = get_ov(sel);
      od = sel ? b1.out_data : b0.out_data;
      ol = sel ? b1.out_last : b0.out_last;
      if (stalled && (!ov || od !== hold)) unstable = 1;
      rdy = toggle ? !rdy : 1'b1;
      if (sel) b1.out_ready = rdy; else b0.out_ready = rdy;
      if (ov && rdy) begin
        if (n >= exp.len() || od !== exp[n]) bad++;
        if (ol !== (n == exp.len() - 1)) lastbad = 1;
        n++;
        stalled = 0;
        if (ol === 1'b1) done = 1;
      end else if (ov) begin
        stalled = 1;
        hold = od;
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_len"}, 32'(n), 32'(exp.len()));
    chk({tag, "_chars"}, 32'(bad), 32'd0);
    chk({tag, "_last"}, 32'(lastbad), 32'd0);
    chk({tag, "_stable"}, 32'(unstable), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_ov_after"}, 32'(get_ov(sel)), 32'd0);
    chk({tag, "_ready_after"}, 32'(sel ? b1.in_ready : b0.in_ready), 32'd1);
    chk({tag, "_busy_after"}, 32'(sel ? b1.busy : b0.busy), 32'd0);
    b0.out_ready = 1'b0; b1.out_ready = 1'b0;
  endtask

  initial begin
    b0.in_valid = 0; b0.result_integer = 0; b0.result_decimal = 0; b0.out_ready = 0;
    b1.in_valid = 0; b1.result_integer = 0; b1.result_decimal = 0; b1.out_ready = 0;
    #12;
    chk("rst_in_ready", 32'(b0.in_ready), 32'd1);
    chk("rst_out_valid", 32'(b0.out_valid), 32'd0);
    chk("rst_out_data", 32'(b0.out_data), 32'h00);
    chk("rst_out_last", 32'(b0.out_last), 32'd0);
    chk("rst_busy", 32'(b0.busy), 32'd0);
    rst_n = 1'b1;

    // 3.5 with latency check: out_valid rises on the 9th edge after accept.
    send(0, 8'd3, 23'h400000);
    chk("busy_after_accept", 32'(b0.busy), 32'd1);
    chk("in_ready_after_accept", 32'(b0.in_ready), 32'd0);
    begin
      int early = 0;
      for (int e = 1; e <= 8; e++) begin
        @(posedge clk); #1;
        if (b0.out_valid) early++;
      end
      chk("latency_no_early_valid", 32'(early), 32'd0);
      @(posedge clk); #1;
      chk("latency_valid_edge9", 32'(b0.out_valid), 32'd1);
    end
    collect(0, "3.5000", 0, "c1");

    send(0, 8'hFF, 23'h400000);
    collect(0, "-0.5000", 0, "c2");
    send(0, 8'h80, 23'h000000);
    collect(0, "-128.0000", 0, "c3a");
    send(0, 8'h00, 23'h000000);
    collect(0, "0.0000", 0, "c3b");
    send(0, 8'h00, 23'h7FFFFF);
    collect(0, "0.9999", 0, "c4a");
    send(0, 8'hF3, 23'h500000);
    collect(0, "-12.3750", 0, "c_neg12");
    send(1, 8'd100, 23'h000000);
    collect(1, "100", 0, "c4b");
    send(1, 8'hFF, 23'h7FFFFF);
    collect(1, "-0", 0, "c4c");

    // Stalls plus in_valid pulses while busy.
    send(0, 8'd3, 23'h400000);
    fork
      collect(0, "3.5000", 1, "c5");
      begin
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          b0.result_integer = 8'd7; b0.result_decimal = 23'h123456; b0.in_valid = 1'b1;
          @(negedge clk);
          b0.in_valid = 1'b0;
        end
      end
    join
    begin
      int extra = 0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (b0.out_valid) extra++;
      end
      chk("c5_no_extra_string", 32'(extra), 32'd0);
    end

    // Reset while the third character of "-128.0000" is presented.
    send(0, 8'h80, 23'h000000);
    begin
      int xfers = 0, cyc = 0;
      bit hit = 0;
      b0.out_ready = 1'b1;
      while (!hit && cyc < 100) begin
        @(negedge clk); cyc++;
        if (b0.out_valid) begin
          if (xfers == 2) begin
            chk("c6_third_char", 32'(b0.out_data), 32'h32);
            rst_n = 1'b0;
            hit = 1;
          end else begin
            xfers++;
          end
        end
      end
      chk("c6_reached_third", 32'(hit), 32'd1);
      #1;
      chk("c6_rst_out_valid", 32'(b0.out_valid), 32'd0);
      chk("c6_rst_in_ready", 32'(b0.in_ready), 32'd1);
      chk("c6_rst_busy", 32'(b0.busy), 32'd0);
      chk("c6_rst_out_data", 32'(b0.out_data), 32'h00);
      b0.out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      begin
        int stray = 0;
        for (int j = 0; j < 12; j++) begin
          @(negedge clk);
          if (b0.out_valid) stray++;
        end
        chk("c6_no_resume", 32'(stray), 32'd0);
      end
    end
    send(0, 8'd3, 23'h400000);
    collect(0, "3.5000", 0, "c6_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
